// File: rtl/radar_statistics_pkg.sv
// Shared constants for the radar statistics block: default measurement width
// and the all-ones saturation pattern that every counter clamps to.
package radar_statistics_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Widest measurement supported; narrower instances take the low bits.
    localparam int MAX_DATA_WIDTH = 64;
    localparam logic [MAX_DATA_WIDTH-1:0] SAT_VALUE = '1;

endpackage

// File: rtl/clk_divider.sv
// Free-running clock divider: output starts low and toggles every RATIO/2
// input cycles, giving a 50% duty clock with period RATIO.
module clk_divider #(
    parameter int RATIO = 2
) (
    input  logic clk,
    output logic clk_div
);

    localparam logic [31:0] HALF_M1 = 32'(RATIO / 2 - 1);

    // No reset port exists, so power-up values define the starting phase.
    logic [31:0] cnt   = '0;
    logic        div_q = 1'b0;

    always_ff @(posedge clk) begin
        if (cnt == HALF_M1) begin
            cnt   <= '0;
            div_q <= ~div_q;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign clk_div = div_q;

endmodule

// File: rtl/radar_statistics_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a single
// SYS_CLK-wide pulse per rising edge of an asynchronous input.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    // Stages 0 and 1 form the synchronizer, stage 2 holds the previous level.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/radar_statistics.sv
// Measures antenna revolution time, azimuth pulses per revolution and the
// transmit trigger period, all in microsecond ticks of US_CLK.
module radar_statistics
    import radar_statistics_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  SYS_CLK,
    input  logic                  RESET,
    input  logic                  ARP,
    input  logic                  ACP,
    input  logic                  TRIG,
    input  logic                  US_CLK,
    output logic                  CALIBRATED,
    output logic [DATA_WIDTH-1:0] ARP_US,
    output logic [DATA_WIDTH-1:0] ACP_CNT,
    output logic [DATA_WIDTH-1:0] TRIG_US
);

    localparam logic [DATA_WIDTH-1:0] SAT = SAT_VALUE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic arp_e, acp_e, trig_e, us_e;

    logic [DATA_WIDTH-1:0] arp_cnt, acp_cnt, trig_cnt;
    logic                  arp_seen, arp_done, trig_seen, trig_done;

    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
        return (v == SAT) ? v : v + ONE;
    endfunction

    sync_edge_detect u_arp_edge  (.clk(SYS_CLK), .reset(RESET), .sig(ARP),    .rise(arp_e));
    sync_edge_detect u_acp_edge  (.clk(SYS_CLK), .reset(RESET), .sig(ACP),    .rise(acp_e));
    sync_edge_detect u_trig_edge (.clk(SYS_CLK), .reset(RESET), .sig(TRIG),   .rise(trig_e));
    sync_edge_detect u_us_edge   (.clk(SYS_CLK), .reset(RESET), .sig(US_CLK), .rise(us_e));

    // A tick coinciding with the reference edge belongs to the new period,
    // so the published value excludes it and the restart value includes it.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            arp_cnt  <= '0;
            acp_cnt  <= '0;
            arp_seen <= 1'b0;
            arp_done <= 1'b0;
            ARP_US   <= '0;
            ACP_CNT  <= '0;
        end else if (arp_e) begin
            arp_cnt  <= us_e  ? ONE : '0;
            acp_cnt  <= acp_e ? ONE : '0;
            arp_seen <= 1'b1;
            if (arp_seen) begin
                ARP_US   <= arp_cnt;
                ACP_CNT  <= acp_cnt;
                arp_done <= 1'b1;
            end
        end else begin
            if (us_e) begin
                arp_cnt <= sat_inc(arp_cnt);
            end
            if (acp_e) begin
                acp_cnt <= sat_inc(acp_cnt);
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            trig_cnt  <= '0;
            trig_seen <= 1'b0;
            trig_done <= 1'b0;
            TRIG_US   <= '0;
        end else if (trig_e) begin
            trig_cnt  <= us_e ? ONE : '0;
            trig_seen <= 1'b1;
            if (trig_seen) begin
                TRIG_US   <= trig_cnt;
                trig_done <= 1'b1;
            end
        end else if (us_e) begin
            trig_cnt <= sat_inc(trig_cnt);
        end
    end

    // Both done flags are sticky, so this stays high until reset.
    assign CALIBRATED = arp_done & trig_done;

endmodule

// File: tb/tb_radar_statistics.sv
// Bench for radar_statistics: a 32-bit and a 4-bit instance share stimulus and
// are compared against an edge-timestamp model of the measurements.
module tb_radar_statistics;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    logic use_div = 1'b1;
    logic drv_arp = 1'b0, drv_acp = 1'b0, drv_trig = 1'b0, drv_us = 1'b0;
    logic div_arp, div_acp, div_trig, div_us;
    logic arp, acp, trig, us_clk;

    logic        cal32, cal4;
    logic [31:0] arp_us32, acp_cnt32, trig_us32;
    logic [3:0]  arp_us4, acp_cnt4, trig_us4;

    int checks = 0;
    int passes = 0;

    // Model state: cycle index of every rising edge since the last reset.
    int cyc = 0;
    int arp_t[$], acp_t[$], trig_t[$], us_t[$];
    logic lv_arp = 1'b0, lv_acp = 1'b0, lv_trig = 1'b0, lv_us = 1'b0;

    logic [31:0] got[8];
    logic [31:0] exp_v[8];
    string nm[8] = '{"arp_us", "acp_cnt", "trig_us", "calibrated",
                     "arp_us_w4", "acp_cnt_w4", "trig_us_w4", "calibrated_w4"};

    always #5 sys_clk = ~sys_clk;

    clk_divider #(.RATIO(100))   u_div_us   (.clk(sys_clk), .clk_div(div_us));
    clk_divider #(.RATIO(500))   u_div_trig (.clk(sys_clk), .clk_div(div_trig));
    clk_divider #(.RATIO(2500))  u_div_acp  (.clk(sys_clk), .clk_div(div_acp));
    clk_divider #(.RATIO(12500)) u_div_arp  (.clk(sys_clk), .clk_div(div_arp));

    assign arp    = use_div ? div_arp  : drv_arp;
    assign acp    = use_div ? div_acp  : drv_acp;
    assign trig   = use_div ? div_trig : drv_trig;
    assign us_clk = use_div ? div_us   : drv_us;

    radar_statistics #(.DATA_WIDTH(32)) dut (
        .SYS_CLK(sys_clk), .RESET(reset), .ARP(arp), .ACP(acp), .TRIG(trig),
        .US_CLK(us_clk), .CALIBRATED(cal32), .ARP_US(arp_us32),
        .ACP_CNT(acp_cnt32), .TRIG_US(trig_us32)
    );

    radar_statistics #(.DATA_WIDTH(4)) dut4 (
        .SYS_CLK(sys_clk), .RESET(reset), .ARP(arp), .ACP(acp), .TRIG(trig),
        .US_CLK(us_clk), .CALIBRATED(cal4), .ARP_US(arp_us4),
        .ACP_CNT(acp_cnt4), .TRIG_US(trig_us4)
    );

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    function automatic logic [31:0] clamp4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    // Each measurement counts the events whose timestamps fall between the
    // last two reference edges, earlier edge inclusive.
    task automatic compute_expected();
        int na = arp_t.size();
        int nt = trig_t.size();
        int a = 0, c = 0, t = 0;
        if (na >= 2) begin
            a = count_in(us_t,  arp_t[na-2], arp_t[na-1]);
            c = count_in(acp_t, arp_t[na-2], arp_t[na-1]);
        end
        if (nt >= 2) t = count_in(us_t, trig_t[nt-2], trig_t[nt-1]);
        exp_v[0] = 32'(a);
        exp_v[1] = 32'(c);
        exp_v[2] = 32'(t);
        exp_v[3] = (na >= 2 && nt >= 2) ? 32'd1 : 32'd0;
        exp_v[4] = clamp4(a);
        exp_v[5] = clamp4(c);
        exp_v[6] = clamp4(t);
        exp_v[7] = exp_v[3];
    endtask

    task automatic sample_outputs();
        got[0] = arp_us32;
        got[1] = acp_cnt32;
        got[2] = trig_us32;
        got[3] = {31'd0, cal32};
        got[4] = {28'd0, arp_us4};
        got[5] = {28'd0, acp_cnt4};
        got[6] = {28'd0, trig_us4};
        got[7] = {31'd0, cal4};
    endtask

    task automatic apply_stimulus(input logic a, input logic c, input logic t, input logic u);
        @(negedge sys_clk);
        cyc++;
        if (a && !lv_arp)  arp_t.push_back(cyc);
        if (c && !lv_acp)  acp_t.push_back(cyc);
        if (t && !lv_trig) trig_t.push_back(cyc);
        if (u && !lv_us)   us_t.push_back(cyc);
        lv_arp = a; lv_acp = c; lv_trig = t; lv_us = u;
        drv_arp = a; drv_acp = c; drv_trig = t; drv_us = u;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset = 1'b1;
        drv_arp = 1'b0; drv_acp = 1'b0; drv_trig = 1'b0; drv_us = 1'b0;
        lv_arp = 1'b0; lv_acp = 1'b0; lv_trig = 1'b0; lv_us = 1'b0;
        arp_t.delete(); acp_t.delete(); trig_t.delete(); us_t.delete();
        @(negedge sys_clk);
        reset = 1'b0;
    endtask

    // One ARP edge (optionally with a coincident ACP edge) followed by the
    // requested number of ACP, TRIG and US edges, one per two cycles.
    task automatic revolution(input int n_us, input int n_acp, input int n_trig, input logic coin);
        int m = n_us;
        if (n_acp > m)  m = n_acp;
        if (n_trig > m) m = n_trig;
        apply_stimulus(1'b1, coin, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < m; i++) begin
            apply_stimulus(1'b0, i < n_acp, i < n_trig, i < n_us);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'd0)
                $display("[TB] FAIL reset/%s: got %0d, expected 0", nm[i], got[i]);
            else passes++;
        end
        reset = 1'b0;
    endtask

    task automatic test_divider_reference();
        int waited = 0;
        while (!cal32 && waited < 25000) begin
            @(negedge sys_clk);
            waited++;
        end
        checks++;
        if (!cal32) $display("[TB] FAIL divider/calibrate_wait: got 0 after %0d cycles, expected 1", waited);
        else passes++;
        repeat (20) @(negedge sys_clk);
        exp_v = '{32'd125, 32'd5, 32'd5, 32'd1, 32'd15, 32'd5, 32'd5, 32'd1};
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_v[i])
                $display("[TB] FAIL divider/%s: got %0d, expected %0d", nm[i], got[i], exp_v[i]);
            else passes++;
        end
        @(negedge sys_clk);
        use_div = 1'b0;
    endtask

    task automatic test_single_arp();
        do_reset();
        revolution(12, 3, 0, 1'b0);
        idle(8);
        compute_expected();
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_v[i] || got[i] !== 32'd0)
                $display("[TB] FAIL single_arp/%s: got %0d, expected 0", nm[i], got[i]);
            else passes++;
        end
    endtask

    task automatic test_coincident_acp();
        do_reset();
        revolution(9, 4, 1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            revolution(9 + r, 4, 1, 1'b1);
            idle(6);
            compute_expected();
            sample_outputs();
            checks++;
            if (got[1] !== 32'd5 || exp_v[1] !== 32'd5)
                $display("[TB] FAIL coincident_acp/rev%0d: got %0d, expected 5", r, got[1]);
            else passes++;
            checks++;
            if (got[5] !== 32'd5)
                $display("[TB] FAIL coincident_acp_w4/rev%0d: got %0d, expected 5", r, got[5]);
            else passes++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        revolution(20, 0, 0, 1'b0);
        compute_expected();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (arp_us32 !== exp_v[0])
            $display("[TB] FAIL saturation/early_update: got %0d, expected %0d", arp_us32, exp_v[0]);
        else passes++;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        compute_expected();
        checks++;
        if (arp_us32 !== exp_v[0] || exp_v[0] !== 32'd20)
            $display("[TB] FAIL saturation/arp_us: got %0d, expected 20", arp_us32);
        else passes++;
        checks++;
        if (arp_us4 !== 4'd15)
            $display("[TB] FAIL saturation/arp_us_w4: got %0d, expected 15", arp_us4);
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 200; k++) begin
                apply_stimulus(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            end
            idle(6);
            compute_expected();
            sample_outputs();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== exp_v[i])
                    $display("[TB] FAIL random%0d/%s: got %0d, expected %0d", r, nm[i], got[i], exp_v[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        revolution(10, 3, 2, 1'b0);
        revolution(14, 6, 2, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        reset = 1'b1;
        drv_arp = 1'b0; drv_acp = 1'b0; drv_trig = 1'b0; drv_us = 1'b0;
        lv_arp = 1'b0; lv_acp = 1'b0; lv_trig = 1'b0; lv_us = 1'b0;
        arp_t.delete(); acp_t.delete(); trig_t.delete(); us_t.delete();
        @(negedge sys_clk);
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'd0)
                $display("[TB] FAIL mid_reset/%s: got %0d, expected 0", nm[i], got[i]);
            else passes++;
        end
        reset = 1'b0;
        revolution(7, 2, 1, 1'b0);
        idle(6);
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'd0)
                $display("[TB] FAIL post_reset_first/%s: got %0d, expected 0", nm[i], got[i]);
            else passes++;
        end
        revolution(8, 3, 1, 1'b0);
        idle(6);
        compute_expected();
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_v[i])
                $display("[TB] FAIL post_reset_second/%s: got %0d, expected %0d", nm[i], got[i], exp_v[i]);
            else passes++;
        end
    endtask

    task automatic test_trig_stop();
        logic [31:0] held_trig;
        compute_expected();
        held_trig = exp_v[2];
        revolution(11, 4, 0, 1'b0);
        revolution(13, 5, 0, 1'b0);
        idle(6);
        compute_expected();
        sample_outputs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_v[i])
                $display("[TB] FAIL trig_stop/%s: got %0d, expected %0d", nm[i], got[i], exp_v[i]);
            else passes++;
        end
        checks++;
        if (trig_us32 !== held_trig || !cal32)
            $display("[TB] FAIL trig_stop/held: got trig %0d cal %0d, expected trig %0d cal 1",
                     trig_us32, cal32, held_trig);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_divider_reference();
        test_single_arp();
        test_coincident_acp();
        test_saturation();
        test_random();
        test_mid_reset();
        test_trig_stop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/radar_statistics.md
RADAR_STATISTICS -- requirements
Module: radar_statistics

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the width of every measurement output.
REQ-002 The block SHALL have input SYS_CLK, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have input RESET, 1 bit, synchronous, active-high.
REQ-004 The block SHALL have input ARP, 1 bit, azimuth reference pulse, one rising edge per antenna revolution, asynchronous.
REQ-005 The block SHALL have input ACP, 1 bit, azimuth change pulse, asynchronous.
REQ-006 The block SHALL have input TRIG, 1 bit, radar transmit trigger, asynchronous.
REQ-007 The block SHALL have input US_CLK, 1 bit, 1 MHz timebase; each rising edge is one microsecond tick.
REQ-008 The block SHALL have output CALIBRATED, 1 bit, all three measurements valid.
REQ-009 The block SHALL have output ARP_US, DATA_WIDTH bits, microseconds between the last two ARP rising edges.
REQ-010 The block SHALL have output ACP_CNT, DATA_WIDTH bits, ACP rising edges counted in the last complete ARP period.
REQ-011 The block SHALL have output TRIG_US, DATA_WIDTH bits, microseconds between the last two TRIG rising edges.

Function
REQ-012 ARP, ACP, TRIG and US_CLK SHALL each pass through a 2-flop synchronizer plus a rising-edge detector with identical latency, producing 1-cycle pulses arp_e, acp_e, trig_e, us_e.
REQ-013 The ARP period counter SHALL increment on each us_e.
REQ-014 On arp_e, ARP_US SHALL load the ARP period counter value, excluding a coincident us_e.
REQ-015 On arp_e, the ARP period counter SHALL restart at 1 if us_e coincides, else at 0.
REQ-016 The ACP counter SHALL increment on each acp_e.
REQ-017 On arp_e, ACP_CNT SHALL load the ACP counter value, excluding a coincident acp_e.
REQ-018 On arp_e, the ACP counter SHALL restart at 1 if acp_e coincides, else at 0.
REQ-019 The TRIG counter SHALL count us_e between trig_e pulses.
REQ-020 On trig_e, TRIG_US SHALL load the TRIG counter value and the counter SHALL restart, following the same coincidence rule as REQ-014/015.
REQ-021 The first arp_e (or trig_e) after reset SHALL only start its counter and SHALL NOT update its outputs; outputs update from the second edge onward.
REQ-022 Outputs SHALL update one SYS_CLK cycle after the detected edge and hold until the next update.
REQ-023 All counters SHALL saturate at all-ones and never wrap; a saturated value SHALL be published as all-ones.
REQ-024 CALIBRATED SHALL rise in the cycle both ARP_US/ACP_CNT and TRIG_US have received their first update.
REQ-025 CALIBRATED SHALL stay high until reset.

Reset
REQ-026 RESET SHALL clear synchronizers, edge detectors, counters, first-edge flags, ARP_US, ACP_CNT and TRIG_US to 0, and CALIBRATED to 0.
REQ-027 RESET asserted mid-period SHALL discard the partial measurement; measurement restarts per REQ-021.

Structure
REQ-028 DATA_WIDTH default and the saturation value SHALL live in a shared package.
REQ-029 One sub-module SHALL be used: sync_edge_detect (2-flop synchronizer + rising-edge pulse), instantiated four times.
REQ-030 Companion clk_divider SHALL have parameter RATIO and ports (in clock, out clock).
REQ-031 clk_divider's output SHALL start low and toggle every RATIO/2 input cycles, giving period RATIO at 50% duty.

Verification
REQ-032 100 MHz SYS_CLK; clk_divider ratios 100/500/2500/12500 drive US_CLK/TRIG/ACP/ARP -> after second ARP edge TRIG_US=5, ACP_CNT=5, ARP_US=125, CALIBRATED=1.
REQ-033 Reset, then single ARP edge only -> ARP_US=0, ACP_CNT=0, CALIBRATED=0.
REQ-034 ACP edge coincident with ARP edge at every revolution, 5 ACP per revolution -> ACP_CNT=5 on every update.
REQ-035 DATA_WIDTH=4, ARP period 20 us -> ARP_US=15 (saturated).
REQ-036 RESET pulsed mid-revolution -> all outputs 0 immediately.
REQ-037 After REQ-036 reset, first post-reset ARP edge leaves outputs unchanged; second edge restores correct values.
REQ-038 TRIG stopped after calibration -> TRIG_US holds last value and CALIBRATED stays 1.
